score_overlay: RTL and testbench

//  Pixel-pipeline stage between gfx_inst RGB output and HDMI_generator. Counts coin pickups
//  (rising edges of out_coin_hit) in a saturating 4-digit BCD score and draws it as

---
 rtl/score_overlay.sv | 198 +++++++++++++++++++
 tb/tb_score_overlay.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_overlay.sv
// score_overlay: saturating 4-digit BCD coin score drawn as seven-segment digits over gfx RGB.
// Latency: 2 pixel clocks for RGB/de/hs/vs; o_score updates 1 clock after a coin edge.
// Backpressure: none (free-running pixel stream). Optional macro SCORE_FLASH_EN adds a pickup flash.
module score_overlay #(
    parameter logic [15:0] POS_X        = 16'd1100,
    parameter logic [15:0] POS_Y        = 16'd16,
    parameter int          SCALE_LOG2   = 2,
    parameter logic [23:0] FG_RGB       = 24'hFFFF00,
    parameter int          FLASH_FRAMES = 8
) (
    input  logic        i_pix_clk,
    input  logic        i_rst,
    input  logic [15:0] i_sx,
    input  logic [15:0] i_sy,
    input  logic        i_de,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic        i_frame,
    input  logic [7:0]  i_red,
    input  logic [7:0]  i_green,
    input  logic [7:0]  i_blue,
    input  logic        i_coin_hit,
    input  logic        i_clear,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue,
    output logic        o_de,
    output logic        o_hs,
    output logic        o_vs,
    output logic [15:0] o_score
);
    localparam int U = 1 << SCALE_LOG2;
    localparam logic signed [16:0] BOX_W = 17'(24 * U);
    localparam logic signed [16:0] BOX_H = 17'(11 * U);

    logic        coin_q, inc, sat, flash, lower9;
    logic [15:0] score, shown_score, score_inc;

    assign inc = i_coin_hit & ~coin_q;
    assign sat = (score == 16'h9999);

    // A digit rolls over or increments only when every lower digit is 9.
    always_comb begin
        score_inc = score;
        lower9    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (lower9) begin
                if (score[i*4 +: 4] == 4'd9) score_inc[i*4 +: 4] = 4'd0;
                else                         score_inc[i*4 +: 4] = score[i*4 +: 4] + 4'd1;
            end
            lower9 = lower9 & (score[i*4 +: 4] == 4'd9);
        end
    end

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            coin_q      <= 1'b0;
            score       <= '0;
            shown_score <= '0;
        end else begin
            coin_q <= i_coin_hit;
            if (i_clear)          score <= '0;
            else if (inc && !sat) score <= score_inc;
            if (i_frame) shown_score <= score;
        end
    end

    assign o_score = score;

`ifdef SCORE_FLASH_EN
    localparam int FW = $clog2(FLASH_FRAMES + 1);
    logic [FW-1:0] flash_cnt;

    always_ff @(posedge i_pix_clk) begin
        if (i_rst || i_clear)               flash_cnt <= '0;
        else if (inc && !sat)               flash_cnt <= FW'(FLASH_FRAMES);
        else if (i_frame && flash_cnt != 0) flash_cnt <= flash_cnt - FW'(1);
    end
    assign flash = (flash_cnt != '0);
`else
    // Flash never active in this build.
    assign flash = (FLASH_FRAMES < 0);
`endif

    // Stage 1: box hit test and cell-local unit coordinates.
    logic signed [16:0] dx, dy;
    logic               in_box;
    logic [4:0]         ux;
    logic [1:0]         dig;
    logic [2:0]         cx;

    assign dx     = $signed({i_sx[15], i_sx}) - $signed({1'b0, POS_X});
    assign dy     = $signed({i_sy[15], i_sy}) - $signed({1'b0, POS_Y});
    assign in_box = (dx >= 17'sd0) && (dx < BOX_W) && (dy >= 17'sd0) && (dy < BOX_H);
    assign ux     = 5'(dx >>> SCALE_LOG2);

    always_comb begin
        dig = 2'd3;
        cx  = 3'(ux);
        if (ux >= 5'd18)      begin dig = 2'd0; cx = 3'(ux - 5'd18); end
        else if (ux >= 5'd12) begin dig = 2'd1; cx = 3'(ux - 5'd12); end
        else if (ux >= 5'd6)  begin dig = 2'd2; cx = 3'(ux - 5'd6);  end
    end

    logic        s1_in_box, s1_de, s1_hs, s1_vs;
    logic [1:0]  s1_dig;
    logic [2:0]  s1_cx;
    logic [3:0]  s1_cy;
    logic [23:0] s1_rgb;

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            s1_in_box <= 1'b0;
            s1_dig    <= '0;
            s1_cx     <= '0;
            s1_cy     <= '0;
            s1_de     <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_rgb    <= '0;
        end else begin
            s1_in_box <= in_box;
            s1_dig    <= dig;
            s1_cx     <= cx;
            s1_cy     <= 4'(dy >>> SCALE_LOG2);
            s1_de     <= i_de;
            s1_hs     <= i_hs;
            s1_vs     <= i_vs;
            s1_rgb    <= {i_red, i_green, i_blue};
        end
    end

    // Stage 2: segment decode, leading-zero blanking and colour mux.
    logic [3:0]  nib;
    logic [6:0]  segs;
    logic        blank, on_h, top, bot, hit, lit;
    logic [23:0] pix;

    assign nib = shown_score[{s1_dig, 2'b00} +: 4];

    always_comb begin
        case (s1_dig)
            2'd3:    blank = (shown_score[15:12] == 4'd0);
            2'd2:    blank = (shown_score[15:8] == 8'd0);
            2'd1:    blank = (shown_score[15:4] == 12'd0);
            default: blank = 1'b0;
        endcase
    end

    always_comb begin
        case (nib)   // {a,b,c,d,e,f,g}
            4'd0:    segs = 7'h7E;
            4'd1:    segs = 7'h30;
            4'd2:    segs = 7'h6D;
            4'd3:    segs = 7'h79;
            4'd4:    segs = 7'h33;
            4'd5:    segs = 7'h5B;
            4'd6:    segs = 7'h5F;
            4'd7:    segs = 7'h70;
            4'd8:    segs = 7'h7F;
            4'd9:    segs = 7'h7B;
            default: segs = 7'h00;
        endcase
    end

    assign on_h = (s1_cx >= 3'd1) && (s1_cx <= 3'd4);
    assign top  = (s1_cy >= 4'd1) && (s1_cy <= 4'd4);
    assign bot  = (s1_cy >= 4'd6) && (s1_cy <= 4'd9);
    assign hit  = (segs[6] && s1_cy == 4'd0  && on_h) ||
                  (segs[5] && s1_cx == 3'd5  && top)  ||
                  (segs[4] && s1_cx == 3'd5  && bot)  ||
                  (segs[3] && s1_cy == 4'd10 && on_h) ||
                  (segs[2] && s1_cx == 3'd0  && bot)  ||
                  (segs[1] && s1_cx == 3'd0  && top)  ||
                  (segs[0] && s1_cy == 4'd5  && on_h);
    assign lit  = s1_in_box && !blank && hit;

    always_comb begin
        pix = s1_rgb;
        if (lit)                     pix = flash ? ~FG_RGB : FG_RGB;
        else if (s1_in_box && flash) pix = FG_RGB;
        if (!s1_de)                  pix = '0;
    end

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            {o_red, o_green, o_blue} <= '0;
            o_de <= 1'b0;
            o_hs <= 1'b0;
            o_vs <= 1'b0;
        end else begin
            {o_red, o_green, o_blue} <= pix;
            o_de <= s1_de;
            o_hs <= s1_hs;
            o_vs <= s1_vs;
        end
    end
endmodule

// File: tb/tb_score_overlay.sv
// Scoreboard bench for score_overlay: a behavioural model pushes the expected pixel for every
// driven cycle; scenario tasks pop it two cycles later and also check hand-derived constants.
module tb_score_overlay;
    localparam logic [23:0] FG = 24'hFFFF00;
    localparam logic [23:0] IN = 24'h123456;
    localparam int U = 4, PX = 1100, PY = 16;
`ifdef SCORE_FLASH_EN
    localparam bit FLASH_ON = 1'b1;
`else
    localparam bit FLASH_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_rst = 1'b1, i_de = 1'b0, i_hs = 1'b0, i_vs = 1'b0, i_frame = 1'b0;
    logic        i_coin_hit = 1'b0, i_clear = 1'b0;
    logic [15:0] i_sx = '0, i_sy = '0;
    logic [7:0]  i_red = '0, i_green = '0, i_blue = '0;
    logic [7:0]  o_red, o_green, o_blue;
    logic        o_de, o_hs, o_vs;
    logic [15:0] o_score;

    always #5 clk = ~clk;

    score_overlay dut (
        .i_pix_clk(clk), .i_rst(i_rst), .i_sx(i_sx), .i_sy(i_sy), .i_de(i_de), .i_hs(i_hs),
        .i_vs(i_vs), .i_frame(i_frame), .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
        .i_coin_hit(i_coin_hit), .i_clear(i_clear), .o_red(o_red), .o_green(o_green),
        .o_blue(o_blue), .o_de(o_de), .o_hs(o_hs), .o_vs(o_vs), .o_score(o_score)
    );

    typedef struct packed {logic de; logic hs; logic vs; logic [23:0] rgb;} pix_t;
    pix_t q[$];
    int   tests = 0, fails = 0;
    int   m_score = 0, m_shown = 0, m_flash = 0;
    logic m_coin_prev = 1'b0;
    string seg_str [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg",
                            "abc", "abcdefg", "abcdfg"};

    function automatic byte seg_at(input int cx, input int cy);
        bit h = (cx >= 1 && cx <= 4);
        if (cy == 0 && h)                return "a";
        if (cy == 5 && h)                return "g";
        if (cy == 10 && h)               return "d";
        if (cx == 0 && cy >= 1 && cy <= 4) return "f";
        if (cx == 5 && cy >= 1 && cy <= 4) return "b";
        if (cx == 0 && cy >= 6 && cy <= 9) return "e";
        if (cx == 5 && cy >= 6 && cy <= 9) return "c";
        return 8'd0;
    endfunction

    function automatic logic [23:0] model_rgb(input int sx, input int sy, input logic [23:0] rin);
        int  dx = sx - PX, dy = sy - PY;
        int  place, pw, digit;
        byte s;
        bit  lit = 1'b0, fl = FLASH_ON && (m_flash != 0);
        if (dx < 0 || dy < 0 || dx >= 24 * U || dy >= 11 * U) return rin;
        place = 3 - dx / (6 * U);
        pw = 1;
        for (int k = 0; k < place; k++) pw = pw * 10;
        digit = (m_shown / pw) % 10;
        s = seg_at((dx / U) % 6, dy / U);
        if ((place == 0 || m_shown >= pw) && s != 8'd0)
            for (int k = 0; k < seg_str[digit].len(); k++)
                if (seg_str[digit][k] == s) lit = 1'b1;
        if (lit) return fl ? ~FG : FG;
        return fl ? FG : rin;
    endfunction

    // Drives one pixel-clock cycle at the falling edge, pops the expectation due now.
    task automatic pix_cycle(input int sx, input int sy, input logic de, input logic hs,
                             input logic vs, input logic frame, input logic coin,
                             input logic clr, input logic [23:0] rgb,
                             output bit got, output pix_t e);
        pix_t n;
        @(negedge clk);
        got = (q.size() == 2);
        e   = got ? q.pop_front() : '0;
        i_rst = 1'b0; i_sx = 16'(sx); i_sy = 16'(sy); i_de = de; i_hs = hs; i_vs = vs;
        i_frame = frame; i_coin_hit = coin; i_clear = clr; {i_red, i_green, i_blue} = rgb;
        if (frame) m_shown = m_score;
        if (clr) begin
            m_score = 0; m_flash = 0;
        end else if (coin && !m_coin_prev && m_score < 9999) begin
            m_score++; m_flash = 8;
        end else if (frame && m_flash > 0) m_flash--;
        m_coin_prev = coin;
        n.de = de; n.hs = hs; n.vs = vs;
        n.rgb = de ? model_rgb(sx, sy, rgb) : 24'h0;
        q.push_back(n);
    endtask

    task automatic test_reset();
        bit got; pix_t e;
        logic [2:0] pat [6] = '{3'b100, 3'b010, 3'b111, 3'b001, 3'b101, 3'b000};
        @(negedge clk);
        i_rst = 1'b1; i_de = 1'b1; i_hs = 1'b1; i_vs = 1'b1; i_coin_hit = 1'b1;
        {i_red, i_green, i_blue} = 24'hFFFFFF;
        repeat (3) @(negedge clk);
        tests++;
        if ({o_de, o_hs, o_vs, o_red, o_green, o_blue, o_score} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h required 0",
                     {o_de, o_hs, o_vs, o_red, o_green, o_blue, o_score});
        end
        q.delete(); m_score = 0; m_shown = 0; m_flash = 0; m_coin_prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) pix_cycle(10, 10, pat[i][2], pat[i][1], pat[i][0], 0, 0, 0, 24'hA5C30F, got, e);
            else       pix_cycle(0, 0, 0, 0, 0, 0, 0, 0, 24'h0, got, e);
            tests++;
            if ({o_de, o_hs, o_vs, o_red, o_green, o_blue} !== e) begin
                fails++;
                $display("FAIL reset_release cyc %0d: got %h required %h", i,
                         {o_de, o_hs, o_vs, o_red, o_green, o_blue}, e);
            end
        end
    endtask

    task automatic test_coin_edge();
        bit got; pix_t e;
        for (int i = 0; i < 50; i++) begin
            pix_cycle(0, 0, 0, 0, 0, 0, 1, 0, 24'h0, got, e);
            if (i > 0) begin
                tests++;
                if (o_score !== 16'h0001) begin
                    fails++;
                    $display("FAIL coin_held cyc %0d: score %h required 0001", i, o_score);
                end
            end
        end
        for (int i = 0; i < 21; i++) begin
            pix_cycle(0, 0, 0, 0, 0, 0, (i % 2) == 1, 0, 24'h0, got, e);
            tests++;
            if ({o_de, o_hs, o_vs, o_red, o_green, o_blue} !== e) begin
                fails++;
                $display("FAIL coin_pix cyc %0d: got %h required %h", i,
                         {o_de, o_hs, o_vs, o_red, o_green, o_blue}, e);
            end
        end
        tests++;
        if (o_score !== 16'h0011) begin
            fails++;
            $display("FAIL coin_pulses: score %h required 0011", o_score);
        end
    endtask

    task automatic test_saturate();
        bit got; pix_t e;
        pix_cycle(0, 0, 0, 0, 0, 0, 0, 1, 24'h0, got, e);
        for (int i = 0; i < 9999; i++) begin
            pix_cycle(0, 0, 0, 0, 0, 0, 1, 0, 24'h0, got, e);
            pix_cycle(0, 0, 0, 0, 0, 0, 0, 0, 24'h0, got, e);
        end
        tests++;
        if (o_score !== 16'h9999) begin
            fails++;
            $display("FAIL preload_9999: score %h required 9999", o_score);
        end
        pix_cycle(0, 0, 0, 0, 0, 0, 1, 0, 24'h0, got, e);
        pix_cycle(0, 0, 0, 0, 0, 0, 0, 0, 24'h0, got, e);
        tests++;
        if (o_score !== 16'h9999) begin
            fails++;
            $display("FAIL saturate: score %h required 9999", o_score);
        end
        pix_cycle(0, 0, 0, 0, 0, 0, 1, 1, 24'h0, got, e);
        pix_cycle(0, 0, 0, 0, 0, 0, 0, 0, 24'h0, got, e);
        tests++;
        if (o_score !== 16'h0000) begin
            fails++;
            $display("FAIL clear_wins: score %h required 0000", o_score);
        end
    endtask

    localparam int RX [10] = '{1176, 1104, 1195, 1196, 1176, 1172, 1192, -5, 1176, 1176};
    localparam int RY [10] = '{16, 16, 20, 20, 59, 40, 40, 16, 16, 15};
    localparam logic [23:0] REXP [10] = '{FG, IN, FG, IN, IN, IN, FG, IN, 24'h0, IN};

    task automatic test_render();
        bit got; pix_t e;
        for (int i = 0; i < 14; i++)
            pix_cycle(0, 0, 0, 0, 0, 0, (i % 2) == 1, 0, 24'h0, got, e);
        for (int i = 0; i < 9; i++) begin
            pix_cycle(0, 0, 0, 0, 0, 1, 0, 0, 24'h0, got, e);
            pix_cycle(0, 0, 0, 0, 0, 0, 0, 0, 24'h0, got, e);
        end
        for (int i = 0; i < 12; i++) begin
            if (i < 10) pix_cycle(RX[i], RY[i], i != 8, 0, 0, 0, 0, 0, IN, got, e);
            else        pix_cycle(0, 0, 0, 0, 0, 0, 0, 0, 24'h0, got, e);
            tests++;
            if ({o_de, o_hs, o_vs, o_red, o_green, o_blue} !== e) begin
                fails++;
                $display("FAIL render_model cyc %0d: got %h required %h", i,
                         {o_de, o_hs, o_vs, o_red, o_green, o_blue}, e);
            end
            if (i >= 2) begin
                tests++;
                if ({o_red, o_green, o_blue} !== REXP[i-2]) begin
                    fails++;
                    $display("FAIL render_px (%0d,%0d): rgb %h required %h", RX[i-2], RY[i-2],
                             {o_red, o_green, o_blue}, REXP[i-2]);
                end
            end
        end
    endtask

    task automatic test_tear_and_sync();
        bit got; pix_t e;
        logic [23:0] texp [3] = '{IN, FLASH_ON ? FG : IN, FLASH_ON ? ~FG : FG};
        int pix_at [3] = '{0, 3, 5};
        int k = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 0 || i == 3 || i == 5) pix_cycle(1176, 36, 1, 0, 0, 0, 0, 0, IN, got, e);
            else pix_cycle(0, 0, 0, 0, 0, i == 4, i == 1, 0, 24'h0, got, e);
            tests++;
            if ({o_de, o_hs, o_vs, o_red, o_green, o_blue} !== e) begin
                fails++;
                $display("FAIL tear_model cyc %0d: got %h required %h", i,
                         {o_de, o_hs, o_vs, o_red, o_green, o_blue}, e);
            end
            if (k < 3 && i == pix_at[k] + 2) begin
                tests++;
                if ({o_red, o_green, o_blue} !== texp[k]) begin
                    fails++;
                    $display("FAIL tear_free step %0d: rgb %h required %h", k,
                             {o_red, o_green, o_blue}, texp[k]);
                end
                k++;
            end
        end
        for (int y = 718; y < 732; y++)
            for (int x = 0; x < 1650; x++) begin
                pix_cycle(x, y, x < 1280 && y < 720, x >= 1390 && x < 1430, y >= 725 && y < 730,
                          0, 0, 0, {8'(x), 8'(y), 8'h5A}, got, e);
                tests++;
                if ({o_de, o_hs, o_vs, o_red, o_green, o_blue} !== e) begin
                    fails++;
                    $display("FAIL sync_delay (%0d,%0d): got %h required %h", x, y,
                             {o_de, o_hs, o_vs, o_red, o_green, o_blue}, e);
                end
            end
    endtask

    task automatic test_flash();
        bit got; pix_t e;
        pix_cycle(0, 0, 0, 0, 0, 0, 1, 0, 24'h0, got, e);
        pix_cycle(0, 0, 0, 0, 0, 0, 0, 0, 24'h0, got, e);
        tests++;
        if (o_score !== 16'h0009) begin
            fails++;
            $display("FAIL flash_score: score %h required 0009", o_score);
        end
        for (int k = 0; k <= 8; k++)
            for (int s = 0; s < 7; s++) begin
                pix_cycle(s == 0 ? 1176 : 1172, PY, s == 0 || s == 3, 0, 0, s == 6, 0, 0, IN, got, e);
                tests++;
                if ({o_de, o_hs, o_vs, o_red, o_green, o_blue} !== e) begin
                    fails++;
                    $display("FAIL flash_model k %0d s %0d: got %h required %h", k, s,
                             {o_de, o_hs, o_vs, o_red, o_green, o_blue}, e);
                end
                if (s == 2 || s == 5) begin
                    logic [23:0] want;
                    if (s == 2) want = (FLASH_ON && k < 8) ? ~FG : FG;
                    else        want = (FLASH_ON && k < 8) ? FG : IN;
                    tests++;
                    if ({o_red, o_green, o_blue} !== want) begin
                        fails++;
                        $display("FAIL flash_colour frames %0d %s: rgb %h required %h", k,
                                 s == 2 ? "seg" : "bg", {o_red, o_green, o_blue}, want);
                    end
                end
            end
    endtask

    initial begin
        test_reset();
        test_coin_edge();
        test_saturate();
        test_render();
        test_tear_and_sync();
        test_flash();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
